// File: rtl/count_seq_checker_pkg.sv
// Shared definitions for the 3-bit counter and its receiving-end sequence checker.
package count_seq_checker_pkg;

    localparam int COUNT_W   = 3;
    localparam int COUNT_MAX = (1 << COUNT_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_ERR    = 2'd3
    } chk_state_e;

    // Expected successor of a counter value; wraps from COUNT_MAX to 0.
    function automatic logic [COUNT_W-1:0] count_next(input logic [COUNT_W-1:0] v);
        return v + {{(COUNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// Event counter that sticks at all-ones instead of rolling over.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/count_seq_checker.sv
// Monitors the 3-bit counter bus and its enable: locks onto a clean +1/hold
// sequence, then flags any illegal step and counts errors and wrap-arounds.
module count_seq_checker
    import count_seq_checker_pkg::*;
#(
    parameter int LOCK_CYCLES = 2,
    parameter int ERR_W       = 8,
    parameter int WRAP_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              q2,
    input  logic              q1,
    input  logic              q0,
    output logic              locked,
    output logic              seq_err,
    output logic              wrap,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CYCLES);

    logic [COUNT_W-1:0] cur;
    logic [COUNT_W-1:0] bus_prev_q;
    logic               en_prev_q;

    chk_state_e state_q, state_d;
    logic [3:0] good_q, good_d;
    logic       locked_q;
    logic       seq_err_q, seq_err_d;
    logic       wrap_q, wrap_d;

    logic valid_adv;
    logic valid_hold;
    logic step_ok;
    logic is_wrap;

    assign cur        = {q2, q1, q0};
    assign valid_adv  = en_prev_q & (cur == count_next(bus_prev_q));
    assign valid_hold = ~en_prev_q & (cur == bus_prev_q);
    assign step_ok    = valid_adv | valid_hold;
    assign is_wrap    = valid_adv & (bus_prev_q == COUNT_W'(COUNT_MAX));

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        seq_err_d = 1'b0;
        wrap_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_SYNC;
                good_d  = '0;
            end
            ST_SYNC: begin
                wrap_d = is_wrap;
                if (valid_adv) begin
                    good_d = good_q + 4'd1;
                    if ((good_q + 4'd1) >= LOCK_TARGET) begin
                        state_d = ST_LOCKED;
                    end
                end else if (!step_ok) begin
                    good_d = '0;
                end
            end
            ST_LOCKED: begin
                wrap_d = is_wrap;
                if (!step_ok) begin
                    state_d   = ST_ERR;
                    seq_err_d = 1'b1;
                    good_d    = '0;
                end
            end
            ST_ERR: begin
                // Sample just after a fault carries no usable history.
                state_d = ST_SYNC;
            end
            default: begin
                state_d = ST_IDLE;
                good_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            good_q     <= '0;
            locked_q   <= 1'b0;
            seq_err_q  <= 1'b0;
            wrap_q     <= 1'b0;
            bus_prev_q <= '0;
            en_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            locked_q   <= (state_d == ST_LOCKED);
            seq_err_q  <= seq_err_d;
            wrap_q     <= wrap_d;
            bus_prev_q <= cur;
            en_prev_q  <= clk_en;
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (seq_err_d),
        .cnt   (err_cnt)
    );

    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wrap_d),
        .cnt   (wrap_cnt)
    );

    assign locked  = locked_q;
    assign seq_err = seq_err_q;
    assign wrap    = wrap_q;

endmodule
